// File: rtl/demux_wb.sv
// Write-back demultiplexer: a 2-entry {select, data} FIFO that commits one word
// per unstalled cycle into one of eight destination registers, with a one-hot strobe.
module demux_wb #(
  parameter int bus_width    = 16,
  parameter int select_width = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [bus_width-1:0]    data_in,
  input  logic [select_width-1:0] select,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic                    hold,
  output logic [bus_width-1:0]    data_out_0,
  output logic [bus_width-1:0]    data_out_1,
  output logic [bus_width-1:0]    data_out_2,
  output logic [bus_width-1:0]    data_out_3,
  output logic [bus_width-1:0]    data_out_4,
  output logic [bus_width-1:0]    data_out_5,
  output logic [bus_width-1:0]    data_out_6,
  output logic [bus_width-1:0]    data_out_7,
  output logic [7:0]              wr_strobe,
  output logic [1:0]              fifo_count
);

  localparam int num_dest = 2 ** select_width;

  logic [select_width-1:0] r_fifo_sel  [2];
  logic [bus_width-1:0]    r_fifo_data [2];
  logic                    r_wr_ptr;
  logic                    r_rd_ptr;
  logic [1:0]              r_count;
  logic [bus_width-1:0]    r_data_out  [num_dest];
  logic [7:0]              r_wr_strobe;

  logic                    w_push;
  logic                    w_pop;
  logic [select_width-1:0] w_head_sel;
  logic [bus_width-1:0]    w_head_data;

  // Handshake: a word transfers on a rising edge where wr_valid and wr_ready are
  // both high; wr_ready depends only on occupancy, never on wr_valid, hold or a pop.
  assign wr_ready    = (r_count < 2'd2);
  assign w_push      = wr_valid & wr_ready;
  assign w_pop       = (r_count != 2'd0) & ~hold;
  assign w_head_sel  = r_fifo_sel[r_rd_ptr];
  assign w_head_data = r_fifo_data[r_rd_ptr];

  // The FIFO storage itself is not reset; occupancy and pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push && !rst) begin
      r_fifo_sel[r_wr_ptr]  <= select;
      r_fifo_data[r_wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < num_dest; i++) r_data_out[i] <= '0;
      r_wr_strobe <= 8'd0;
    end else if (w_pop) begin
      r_data_out[w_head_sel] <= w_head_data;
      r_wr_strobe            <= 8'd1 << w_head_sel;
    end else begin
      r_wr_strobe <= 8'd0;
    end
  end

  assign data_out_0 = r_data_out[0];
  assign data_out_1 = r_data_out[1];
  assign data_out_2 = r_data_out[2];
  assign data_out_3 = r_data_out[3];
  assign data_out_4 = r_data_out[4];
  assign data_out_5 = r_data_out[5];
  assign data_out_6 = r_data_out[6];
  assign data_out_7 = r_data_out[7];
  assign wr_strobe  = r_wr_strobe;
  assign fifo_count = r_count;

endmodule
